// File: rtl/frogger_game_fsm.sv
// Frogger game-state sequencer: start/restart, lives, post-death freeze and the
// win / game-over outcome. All outputs come straight from flops.
module frogger_game_fsm #(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned WIN_SCORE    = 5,
   parameter int unsigned DEATH_CYCLES = 25_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Start,
   input  logic       i_Collided,
   input  logic [6:0] i_Score,
   output logic       o_Game_Active,
   output logic       o_Kill,
   output logic       o_Score_Clr,
   output logic [3:0] o_Lives,
   output logic [2:0] o_State,
   output logic       o_Game_Over,
   output logic       o_Win
);

   localparam int unsigned TIMER_W = $clog2(DEATH_CYCLES + 1);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StPlay     = 3'd1;
   localparam logic [2:0] StDying    = 3'd2;
   localparam logic [2:0] StGameOver = 3'd3;
   localparam logic [2:0] StWin      = 3'd4;

   localparam logic [TIMER_W-1:0] TimerLoad  = TIMER_W'(DEATH_CYCLES - 1);
   localparam logic [3:0]         LivesInit  = 4'(LIVES);
   localparam logic [6:0]         WinThresh  = 7'(WIN_SCORE);

   logic [2:0]         state_q, state_d;
   logic [3:0]         lives_q, lives_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               kill_q, kill_d;
   logic               clr_q, clr_d;
   logic               active_q, game_over_q, win_q;
   logic               prev_start_q, prev_coll_q;
   logic               start_edge, coll_edge;

   assign start_edge = i_Start & ~prev_start_q;
   assign coll_edge  = i_Collided & ~prev_coll_q;

   // Next-state, lives, freeze timer and one-cycle pulse requests.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      timer_d = timer_q;
      kill_d  = 1'b0;
      clr_d   = 1'b0;
      case (state_q)
         StIdle, StGameOver, StWin: begin
            if (start_edge) begin
               state_d = StPlay;
               lives_d = LivesInit;
               clr_d   = 1'b1;
            end
         end
         StPlay: begin
            // Reaching the win score takes priority over a same-cycle hit.
            if (i_Score >= WinThresh) begin
               state_d = StWin;
            end else if (coll_edge) begin
               kill_d = 1'b1;
               if (lives_q > 4'd1) begin
                  state_d = StDying;
                  lives_d = lives_q - 4'd1;
                  timer_d = TimerLoad;
               end else begin
                  state_d = StGameOver;
                  lives_d = 4'd0;
               end
            end
         end
         StDying: begin
            if (timer_q == '0) begin
               state_d = StPlay;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counters and registered outputs; prev_start resets high so a
   // button held through reset is not seen as a press.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q      <= StIdle;
         lives_q      <= 4'd0;
         timer_q      <= '0;
         kill_q       <= 1'b0;
         clr_q        <= 1'b0;
         active_q     <= 1'b0;
         game_over_q  <= 1'b0;
         win_q        <= 1'b0;
         prev_start_q <= 1'b1;
         prev_coll_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         timer_q      <= timer_d;
         kill_q       <= kill_d;
         clr_q        <= clr_d;
         active_q     <= (state_d == StPlay);
         game_over_q  <= (state_d == StGameOver);
         win_q        <= (state_d == StWin);
         prev_start_q <= i_Start;
         prev_coll_q  <= i_Collided;
      end
   end

   assign o_Game_Active = active_q;
   assign o_Kill        = kill_q;
   assign o_Score_Clr   = clr_q;
   assign o_Lives       = lives_q;
   assign o_State       = state_q;
   assign o_Game_Over   = game_over_q;
   assign o_Win         = win_q;

endmodule
